// File: rtl/vx_dram_req_arb_if.sv
// Bundles the cache-side request/response ports and the shared DRAM-side
// port of vx_dram_req_arb.
// Ports (signal groups):
//   req_in_*  : NUM_REQS packed request channels from the caches
//   req_out_* : merged, registered request channel toward DRAM
//   rsp_in_*  : DRAM response channel, tag carries the requester index
//   rsp_out_* : per-requester response channels (data/tag broadcast)
// Modports: slave = arbiter view, master = environment view.
interface vx_dram_req_arb_if #(
  parameter int unsigned NUM_REQS   = 2,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned TAG_IN_W   = 8
);
  localparam int unsigned LOG_REQS  = $clog2(NUM_REQS);
  localparam int unsigned TAG_OUT_W = TAG_IN_W + LOG_REQS;
  localparam int unsigned BYTEEN_W  = DATA_WIDTH / 8;

  logic [NUM_REQS-1:0]            req_in_valid;
  logic [NUM_REQS-1:0]            req_in_rw;
  logic [NUM_REQS*BYTEEN_W-1:0]   req_in_byteen;
  logic [NUM_REQS*ADDR_WIDTH-1:0] req_in_addr;
  logic [NUM_REQS*DATA_WIDTH-1:0] req_in_data;
  logic [NUM_REQS*TAG_IN_W-1:0]   req_in_tag;
  logic [NUM_REQS-1:0]            req_in_ready;

  logic                           req_out_valid;
  logic                           req_out_rw;
  logic [BYTEEN_W-1:0]            req_out_byteen;
  logic [ADDR_WIDTH-1:0]          req_out_addr;
  logic [DATA_WIDTH-1:0]          req_out_data;
  logic [TAG_OUT_W-1:0]           req_out_tag;
  logic                           req_out_ready;

  logic                           rsp_in_valid;
  logic [DATA_WIDTH-1:0]          rsp_in_data;
  logic [TAG_OUT_W-1:0]           rsp_in_tag;
  logic                           rsp_in_ready;

  logic [NUM_REQS-1:0]            rsp_out_valid;
  logic [NUM_REQS*DATA_WIDTH-1:0] rsp_out_data;
  logic [NUM_REQS*TAG_IN_W-1:0]   rsp_out_tag;
  logic [NUM_REQS-1:0]            rsp_out_ready;

  modport slave (
    input  req_in_valid, req_in_rw, req_in_byteen, req_in_addr, req_in_data, req_in_tag,
    output req_in_ready,
    output req_out_valid, req_out_rw, req_out_byteen, req_out_addr, req_out_data, req_out_tag,
    input  req_out_ready,
    input  rsp_in_valid, rsp_in_data, rsp_in_tag,
    output rsp_in_ready,
    output rsp_out_valid, rsp_out_data, rsp_out_tag,
    input  rsp_out_ready
  );

  modport master (
    output req_in_valid, req_in_rw, req_in_byteen, req_in_addr, req_in_data, req_in_tag,
    input  req_in_ready,
    input  req_out_valid, req_out_rw, req_out_byteen, req_out_addr, req_out_data, req_out_tag,
    output req_out_ready,
    output rsp_in_valid, rsp_in_data, rsp_in_tag,
    input  rsp_in_ready,
    input  rsp_out_valid, rsp_out_data, rsp_out_tag,
    output rsp_out_ready
  );
endinterface

// File: rtl/vx_dram_req_arb.sv
// Shares one DRAM request/response port among NUM_REQS caches.
// Requests: round-robin arbitration into a 1-entry output register; the
// requester index is appended to the tag LSBs. Responses: routed back
// combinationally by those tag LSBs.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : vx_dram_req_arb_if.slave (all request/response channels)
module vx_dram_req_arb #(
  parameter int unsigned NUM_REQS   = 2,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned TAG_IN_W   = 8
) (
  input logic               clk,
  input logic               reset,
  vx_dram_req_arb_if.slave  bus
);
  localparam int unsigned LOG_REQS  = $clog2(NUM_REQS);
  localparam int unsigned TAG_OUT_W = TAG_IN_W + LOG_REQS;
  localparam int unsigned BYTEEN_W  = DATA_WIDTH / 8;

  logic [LOG_REQS-1:0]   ptr_q;
  logic [LOG_REQS-1:0]   grant_c;
  logic                  found_c;
  logic                  buf_free_c;
  logic                  fire_c;

  logic                  out_valid_q;
  logic                  out_rw_q;
  logic [BYTEEN_W-1:0]   out_byteen_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [TAG_OUT_W-1:0]  out_tag_q;

  logic                  sel_rw_c;
  logic [BYTEEN_W-1:0]   sel_byteen_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_data_c;
  logic [TAG_IN_W-1:0]   sel_tag_c;

  logic [LOG_REQS-1:0]   rsp_sel_c;

  // Round-robin search starting at ptr; index arithmetic wraps since NUM_REQS is a power of 2
  always_comb begin
    logic [LOG_REQS-1:0] idx;
    idx     = '0;
    grant_c = '0;
    found_c = 1'b0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      idx = ptr_q + LOG_REQS'(i);
      if (!found_c && bus.req_in_valid[idx]) begin
        grant_c = idx;
        found_c = 1'b1;
      end
    end
  end

  // Output register can take a new entry when empty or draining this cycle
  assign buf_free_c = !out_valid_q || bus.req_out_ready;
  assign fire_c     = buf_free_c && found_c && !reset;

  // Grant mux and per-requester ready
  always_comb begin
    bus.req_in_ready = '0;
    sel_rw_c         = 1'b0;
    sel_byteen_c     = '0;
    sel_addr_c       = '0;
    sel_data_c       = '0;
    sel_tag_c        = '0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      if (grant_c == LOG_REQS'(k)) begin
        bus.req_in_ready[k] = fire_c && bus.req_in_valid[k];
        sel_rw_c            = bus.req_in_rw[k];
        sel_byteen_c        = bus.req_in_byteen[k*BYTEEN_W +: BYTEEN_W];
        sel_addr_c          = bus.req_in_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data_c          = bus.req_in_data[k*DATA_WIDTH +: DATA_WIDTH];
        sel_tag_c           = bus.req_in_tag[k*TAG_IN_W +: TAG_IN_W];
      end
    end
  end

  // Output register and round-robin pointer; payload holds unless a new grant lands
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_rw_q     <= 1'b0;
      out_byteen_q <= '0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_tag_q    <= '0;
      ptr_q        <= '0;
    end else if (fire_c) begin
      out_valid_q  <= 1'b1;
      out_rw_q     <= sel_rw_c;
      out_byteen_q <= sel_byteen_c;
      out_addr_q   <= sel_addr_c;
      out_data_q   <= sel_data_c;
      out_tag_q    <= {sel_tag_c, grant_c};
      ptr_q        <= grant_c + LOG_REQS'(1);
    end else if (bus.req_out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign bus.req_out_valid  = out_valid_q;
  assign bus.req_out_rw     = out_rw_q;
  assign bus.req_out_byteen = out_byteen_q;
  assign bus.req_out_addr   = out_addr_q;
  assign bus.req_out_data   = out_data_q;
  assign bus.req_out_tag    = out_tag_q;

  // Response routing by requester index held in the tag LSBs
  assign rsp_sel_c        = bus.rsp_in_tag[LOG_REQS-1:0];
  assign bus.rsp_in_ready = bus.rsp_out_ready[rsp_sel_c];
  assign bus.rsp_out_data = {NUM_REQS{bus.rsp_in_data}};
  assign bus.rsp_out_tag  = {NUM_REQS{bus.rsp_in_tag[TAG_OUT_W-1:LOG_REQS]}};

  always_comb begin
    bus.rsp_out_valid = '0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      bus.rsp_out_valid[k] = bus.rsp_in_valid && (rsp_sel_c == LOG_REQS'(k));
    end
  end

  // Payload must stay put while stalled downstream
  assert property (@(posedge clk) disable iff (reset)
    (out_valid_q && !bus.req_out_ready) |=>
      $stable({out_rw_q, out_byteen_q, out_addr_q, out_data_q, out_tag_q}));

  assert property (@(posedge clk) $onehot0(bus.req_in_ready));

endmodule

// File: tb/tb_vx_dram_req_arb.sv
module tb_vx_dram_req_arb;
  localparam int unsigned NUM_REQS   = 2;
  localparam int unsigned DATA_WIDTH = 128;
  localparam int unsigned ADDR_WIDTH = 28;
  localparam int unsigned TAG_IN_W   = 8;
  localparam int unsigned BE_W       = DATA_WIDTH / 8;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  vx_dram_req_arb_if #(
    .NUM_REQS(NUM_REQS), .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .TAG_IN_W(TAG_IN_W)
  ) bus_if ();

  vx_dram_req_arb #(
    .NUM_REQS(NUM_REQS), .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .TAG_IN_W(TAG_IN_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic rw, input logic [BE_W-1:0] be,
                         input logic [ADDR_WIDTH-1:0] addr, input logic [DATA_WIDTH-1:0] data,
                         input logic [TAG_IN_W-1:0] tag);
    bus_if.req_in_rw[i]                            = rw;
    bus_if.req_in_byteen[i*BE_W +: BE_W]           = be;
    bus_if.req_in_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = addr;
    bus_if.req_in_data[i*DATA_WIDTH +: DATA_WIDTH] = data;
    bus_if.req_in_tag[i*TAG_IN_W +: TAG_IN_W]      = tag;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.req_in_valid = 2'b11;
    bus_if.req_out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if (bus_if.req_in_ready !== 2'b00) begin
        fails++;
        $display("FAIL reset_ready_in_reset: got %b exp 00", bus_if.req_in_ready);
      end
    end
    tests++;
    if (bus_if.req_out_valid !== 1'b0 || bus_if.req_out_addr !== 28'h0 || bus_if.req_out_tag !== 9'h0) begin
      fails++;
      $display("FAIL reset_out_regs: valid=%b addr=%h tag=%h exp 0/0/0",
               bus_if.req_out_valid, bus_if.req_out_addr, bus_if.req_out_tag);
    end
    reset = 1'b0;
    bus_if.req_in_valid = 2'b00;
    #1;
    tests++;
    if (bus_if.req_out_valid !== 1'b0 || bus_if.req_in_ready !== 2'b00 || bus_if.rsp_out_valid !== 2'b00) begin
      fails++;
      $display("FAIL reset_release: out_valid=%b in_ready=%b rsp_valid=%b exp 0/00/00",
               bus_if.req_out_valid, bus_if.req_in_ready, bus_if.rsp_out_valid);
    end
    step();
    tests++;
    if (bus_if.req_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: out_valid=%b exp 0", bus_if.req_out_valid);
    end
  endtask

  task automatic test_single();
    set_req(1, 1'b1, 16'hF0F0, 28'h100, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 8'h5A);
    bus_if.req_in_valid  = 2'b10;
    bus_if.req_out_ready = 1'b1;
    #1;
    tests++;
    if (bus_if.req_in_ready !== 2'b10) begin
      fails++;
      $display("FAIL single_ready: got %b exp 10", bus_if.req_in_ready);
    end
    step();
    bus_if.req_in_valid = 2'b00;
    tests++;
    if (bus_if.req_out_valid !== 1'b1 || bus_if.req_out_addr !== 28'h100 || bus_if.req_out_tag !== 9'h0B5
        || bus_if.req_out_rw !== 1'b1 || bus_if.req_out_byteen !== 16'hF0F0
        || bus_if.req_out_data !== 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555) begin
      fails++;
      $display("FAIL single_out: valid=%b addr=%h tag=%h rw=%b be=%h exp 1/100/0b5/1/f0f0",
               bus_if.req_out_valid, bus_if.req_out_addr, bus_if.req_out_tag,
               bus_if.req_out_rw, bus_if.req_out_byteen);
    end
    step();
    tests++;
    if (bus_if.req_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_drain: out_valid=%b exp 0", bus_if.req_out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ready;
    logic [8:0] exp_tag;
    set_req(0, 1'b0, 16'hFFFF, 28'h0A0, 128'h0, 8'h10);
    set_req(1, 1'b0, 16'hFFFF, 28'h0A1, 128'h0, 8'h11);
    bus_if.req_in_valid  = 2'b11;
    bus_if.req_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      exp_ready = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_tag   = (c % 2 == 0) ? 9'h020 : 9'h023;
      #1;
      tests++;
      if (bus_if.req_in_ready !== exp_ready) begin
        fails++;
        $display("FAIL rr_ready[%0d]: got %b exp %b", c, bus_if.req_in_ready, exp_ready);
      end
      step();
      tests++;
      if (bus_if.req_out_valid !== 1'b1 || bus_if.req_out_tag !== exp_tag) begin
        fails++;
        $display("FAIL rr_out[%0d]: valid=%b tag=%h exp 1/%h", c,
                 bus_if.req_out_valid, bus_if.req_out_tag, exp_tag);
      end
    end
    bus_if.req_in_valid = 2'b00;
    step();
  endtask

  task automatic test_backpressure();
    set_req(0, 1'b0, 16'h000F, 28'h200, 128'h1234, 8'h33);
    bus_if.req_in_valid  = 2'b01;
    bus_if.req_out_ready = 1'b1;
    step();
    set_req(1, 1'b1, 16'hFF00, 28'h300, 128'h5678, 8'h44);
    bus_if.req_in_valid  = 2'b10;
    bus_if.req_out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests++;
      if (bus_if.req_in_ready !== 2'b00) begin
        fails++;
        $display("FAIL bp_ready[%0d]: got %b exp 00", c, bus_if.req_in_ready);
      end
      step();
      tests++;
      if (bus_if.req_out_valid !== 1'b1 || bus_if.req_out_addr !== 28'h200 || bus_if.req_out_tag !== 9'h066
          || bus_if.req_out_data !== 128'h1234) begin
        fails++;
        $display("FAIL bp_hold[%0d]: valid=%b addr=%h tag=%h exp 1/200/066", c,
                 bus_if.req_out_valid, bus_if.req_out_addr, bus_if.req_out_tag);
      end
    end
    bus_if.req_out_ready = 1'b1;
    #1;
    tests++;
    if (bus_if.req_in_ready !== 2'b10) begin
      fails++;
      $display("FAIL bp_drain_accept: ready=%b exp 10", bus_if.req_in_ready);
    end
    step();
    bus_if.req_in_valid = 2'b00;
    tests++;
    if (bus_if.req_out_valid !== 1'b1 || bus_if.req_out_addr !== 28'h300 || bus_if.req_out_tag !== 9'h089) begin
      fails++;
      $display("FAIL bp_next: valid=%b addr=%h tag=%h exp 1/300/089",
               bus_if.req_out_valid, bus_if.req_out_addr, bus_if.req_out_tag);
    end
    step();
    tests++;
    if (bus_if.req_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_empty: valid=%b exp 0", bus_if.req_out_valid);
    end
  endtask

  task automatic test_response();
    bus_if.rsp_in_valid  = 1'b1;
    bus_if.rsp_in_tag    = 9'h0B5;
    bus_if.rsp_in_data   = 128'hCAFE_F00D;
    bus_if.rsp_out_ready = 2'b01;
    #1;
    tests++;
    if (bus_if.rsp_out_valid !== 2'b10 || bus_if.rsp_out_tag[15:8] !== 8'h5A || bus_if.rsp_in_ready !== 1'b0
        || bus_if.rsp_out_data[255:128] !== 128'hCAFE_F00D) begin
      fails++;
      $display("FAIL rsp_route1: valid=%b tag1=%h rdy=%b exp 10/5a/0",
               bus_if.rsp_out_valid, bus_if.rsp_out_tag[15:8], bus_if.rsp_in_ready);
    end
    bus_if.rsp_out_ready = 2'b10;
    #1;
    tests++;
    if (bus_if.rsp_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rsp_ready1: got %b exp 1", bus_if.rsp_in_ready);
    end
    bus_if.rsp_in_tag = 9'h0B4;
    #1;
    tests++;
    if (bus_if.rsp_out_valid !== 2'b01 || bus_if.rsp_out_tag[7:0] !== 8'h5A || bus_if.rsp_in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rsp_route0: valid=%b tag0=%h rdy=%b exp 01/5a/0",
               bus_if.rsp_out_valid, bus_if.rsp_out_tag[7:0], bus_if.rsp_in_ready);
    end
    bus_if.rsp_in_valid = 1'b0;
    #1;
    tests++;
    if (bus_if.rsp_out_valid !== 2'b00) begin
      fails++;
      $display("FAIL rsp_idle: valid=%b exp 00", bus_if.rsp_out_valid);
    end
    step();
  endtask

  task automatic test_reset_midflight();
    set_req(0, 1'b0, 16'h0001, 28'h400, 128'h9, 8'h21);
    set_req(1, 1'b0, 16'h0002, 28'h401, 128'hA, 8'h22);
    bus_if.req_in_valid  = 2'b01;
    bus_if.req_out_ready = 1'b1;
    step();
    bus_if.req_in_valid  = 2'b00;
    bus_if.req_out_ready = 1'b0;
    step();
    tests++;
    if (bus_if.req_out_valid !== 1'b1 || bus_if.req_out_tag !== 9'h042) begin
      fails++;
      $display("FAIL mid_buffered: valid=%b tag=%h exp 1/042", bus_if.req_out_valid, bus_if.req_out_tag);
    end
    reset = 1'b1;
    bus_if.req_in_valid = 2'b11;
    #1;
    tests++;
    if (bus_if.req_in_ready !== 2'b00) begin
      fails++;
      $display("FAIL mid_ready_in_reset: got %b exp 00", bus_if.req_in_ready);
    end
    step();
    tests++;
    if (bus_if.req_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_discard: valid=%b exp 0", bus_if.req_out_valid);
    end
    reset = 1'b0;
    bus_if.req_out_ready = 1'b1;
    #1;
    tests++;
    if (bus_if.req_in_ready !== 2'b01) begin
      fails++;
      $display("FAIL mid_ptr_reset: ready=%b exp 01", bus_if.req_in_ready);
    end
    step();
    bus_if.req_in_valid = 2'b00;
    tests++;
    if (bus_if.req_out_valid !== 1'b1 || bus_if.req_out_tag !== 9'h042 || bus_if.req_out_addr !== 28'h400) begin
      fails++;
      $display("FAIL mid_regrant: valid=%b tag=%h addr=%h exp 1/042/400",
               bus_if.req_out_valid, bus_if.req_out_tag, bus_if.req_out_addr);
    end
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus_if.req_in_valid  = '0;
    bus_if.req_in_rw     = '0;
    bus_if.req_in_byteen = '0;
    bus_if.req_in_addr   = '0;
    bus_if.req_in_data   = '0;
    bus_if.req_in_tag    = '0;
    bus_if.req_out_ready = 1'b0;
    bus_if.rsp_in_valid  = 1'b0;
    bus_if.rsp_in_data   = '0;
    bus_if.rsp_in_tag    = '0;
    bus_if.rsp_out_ready = '0;

    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_response();
    test_reset_midflight();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
